exc_pipe: RTL and testbench
===========================

Name: exc_pipe

Overview:
- Parametrised exception-tracking pipeline; successor of the fixed 5-stage per-core exception tracker.
- Carries one exception record per stage: valid, cause and tval. Any stage can inject a record.
- At the last (commit) stage, arbitrates between the synchronous exception and masked pending interrupts.
- Presents the chosen trap to the CSR/trap unit through a valid/ack handshake, then drains the pipeline before accepting new traps.

Parameters:
XLEN, 64, width of tval and of trap_cause
NSTG, 5, number of tracked stages; stage 0 is youngest, stage NSTG-1 is commit
CW, 6, width of a synchronous exception cause code
IRQ_W, 16, number of interrupt lines; line k maps to interrupt cause k

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
inj_valid  in  NSTG  per-stage exception detected this cycle
inj_cause  in  NSTG*CW  per-stage cause; slice i = bits [i*CW +: CW]
inj_val  in  NSTG*XLEN  per-stage tval; slice i = bits [i*XLEN +: XLEN]
stall  in  NSTG  per-stage hold
flush  in  NSTG  per-stage kill
commit_valid  in  1  instruction in stage NSTG-1 retires this cycle
irq_pending  in  IRQ_W  pending interrupt lines, already level-synchronised
irq_enable  in  1  global interrupt enable
trap_valid  out  1  trap request to the CSR/trap unit
trap_irq  out  1  trap is an interrupt
trap_cause  out  XLEN  bit XLEN-1 = trap_irq; low bits hold the cause code, zero-extended
trap_val  out  XLEN  tval; 0 for interrupts
trap_ack  in  1  trap unit accepted the trap
busy  out  1  high in TRAP and DRAIN states

Behaviour:
- Reset (asynchronous, rst_n low):
  - all stage v[i]=0, c[i]=0, t[i]=0
  - state=IDLE
  - trap_valid=0, trap_irq=0, trap_cause=0, trap_val=0, busy=0
- Stage update, each rising edge, for stage i. Input record for stage 0 is empty; for i>0 it is stage i-1.
  - flush[i] or state==DRAIN: v[i]<=0. This has the highest priority.
  - !stall[i]:
    - v[i] <= in_v | inj_valid[i]
    - c[i],t[i] <= in_v ? input record : inj slices
    - The older-detected exception (earlier stage) always wins over a later injection on the same instruction.
  - stall[i] & !v[i] & inj_valid[i]: capture the inj slices and set v[i]=1. Exceptions detected while stalled are not lost.
  - stall[i] otherwise: hold.
  - In TRAP state, injections are ignored. Records still shift and honour flush.
- Latency: an injection at stage i with no stalls reaches stage NSTG-1 after NSTG-1-i edges.
- FSM states: IDLE, TRAP, DRAIN.
  - IDLE -> TRAP when commit_valid & (v[NSTG-1] | irq_take), where irq_take = irq_enable & |irq_pending.
    - On that edge, latch outputs and set trap_valid=1.
    - If v[NSTG-1]=1: trap_irq=0, trap_cause=zero-ext c[NSTG-1], trap_val=t[NSTG-1]. The synchronous exception beats an interrupt in the same cycle.
    - Else: trap_irq=1, trap_cause={1, zero-ext index of highest set irq_pending bit}, trap_val=0.
  - TRAP: trap_valid and all trap_* outputs are held stable until trap_ack is sampled high.
    - On that edge: state->DRAIN, trap_valid<=0.
    - irq_pending changes during TRAP do not alter trap_cause.
  - DRAIN: exactly one cycle. All v[i] are cleared on the exit edge. state->IDLE.
  - trap_ack while in IDLE or DRAIN is ignored.
- busy = (state != IDLE). It is driven from the state register, with no combinational path from inputs.
- commit_valid=0 with v[NSTG-1]=1: no trap is taken; the record waits in the stage, subject to stall and flush.
- A flush of stage NSTG-1 in the same cycle as commit_valid: the flush has priority for the stage record. The trap decision still uses the pre-edge record, i.e. the trap is taken.
- NSTG=1 is legal: stage 0 is the commit stage.

Test Plan:
- Exception passes to commit. NSTG=5, no stalls, inj_valid[1]=1, cause=6'd2, val=64'hDEAD, commit_valid=1 throughout.
  -> v[4]=1 three edges later; trap_valid rises next edge with trap_cause=2, trap_val=64'hDEAD, trap_irq=0.
- Older exception wins. Stage 0 inj cause=1 (instr access fault); the same instruction gets inj cause=2 at stage 3.
  -> trap_cause=1, trap_val = stage 0 tval.
- Stalled capture and flush. Stall stage 2 for 3 cycles, inj at stage 2 cause=5 during the stall.
  -> record retained, trap cause=5.
  - Repeat with flush[2] asserted the cycle after injection -> no trap.
- Interrupt arbitration. irq_enable=1, irq_pending=16'h0880, commit_valid=1, no exception.
  -> trap_cause=64'h8000_0000_0000_000B, trap_val=0.
  - Same cycle with v[4]=1 cause=3 -> trap_cause=3, trap_irq=0.
- Handshake hold. Delay trap_ack by 4 cycles and toggle irq_pending meanwhile.
  -> outputs stable, busy=1.
  - After ack: one DRAIN cycle, all stage valids 0, busy=0 the following cycle.
- Asynchronous reset mid-operation. Assert rst_n=0 between clock edges while in TRAP.
  -> trap_valid, busy and all trap_* outputs drop to 0 immediately; state is IDLE after release.

Source files
------------

// File: rtl/exc_pipe.sv
// Exception-tracking pipeline: per-stage exception records shift toward the commit stage,
// where the synchronous exception or a pending interrupt is raised to the trap unit and the pipe is drained.
module exc_pipe #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NSTG  = 5,
  parameter int unsigned CW    = 6,
  parameter int unsigned IRQ_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NSTG-1:0]        inj_valid,
  input  logic [NSTG*CW-1:0]     inj_cause,
  input  logic [NSTG*XLEN-1:0]   inj_val,
  input  logic [NSTG-1:0]        stall,
  input  logic [NSTG-1:0]        flush,
  input  logic                   commit_valid,
  input  logic [IRQ_W-1:0]       irq_pending,
  input  logic                   irq_enable,
  output logic                   trap_valid,
  output logic                   trap_irq,
  output logic [XLEN-1:0]        trap_cause,
  output logic [XLEN-1:0]        trap_val,
  input  logic                   trap_ack,
  output logic                   busy
);

  localparam int unsigned IW   = (IRQ_W > 1) ? $clog2(IRQ_W) : 1;
  localparam int unsigned LAST = NSTG - 1;

  typedef enum logic [1:0] {S_IDLE, S_TRAP, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [NSTG-1:0]     v_q, v_d;
  logic [CW-1:0]       c_q [NSTG];
  logic [CW-1:0]       c_d [NSTG];
  logic [XLEN-1:0]     t_q [NSTG];
  logic [XLEN-1:0]     t_d [NSTG];

  logic                trap_valid_q, trap_valid_d;
  logic                trap_irq_q, trap_irq_d;
  logic [XLEN-1:0]     trap_cause_q, trap_cause_d;
  logic [XLEN-1:0]     trap_val_q, trap_val_d;
  logic                busy_q, busy_d;

  logic [NSTG-1:0]     in_v;
  logic [CW-1:0]       in_c [NSTG];
  logic [XLEN-1:0]     in_t [NSTG];
  logic [NSTG-1:0]     inj_ok_c;
  logic [IW-1:0]       irq_idx_c;
  logic                irq_take_c;

  // Record entering each stage: empty for stage 0, otherwise the previous stage
  for (genvar g = 0; g < NSTG; g++) begin : g_in
    if (g == 0) begin : g_first
      assign in_v[g] = 1'b0;
      assign in_c[g] = '0;
      assign in_t[g] = '0;
    end else begin : g_rest
      assign in_v[g] = v_q[g-1];
      assign in_c[g] = c_q[g-1];
      assign in_t[g] = t_q[g-1];
    end
  end

  assign inj_ok_c   = inj_valid & {NSTG{state_q != S_TRAP}};
  assign irq_take_c = irq_enable & (|irq_pending);

  // Stage record update; the older record always beats a same-instruction injection
  always_comb begin
    v_d = v_q;
    c_d = c_q;
    t_d = t_q;
    for (int i = 0; i < NSTG; i++) begin
      if (flush[i] || (state_q == S_DRAIN)) begin
        v_d[i] = 1'b0;
      end else if (!stall[i]) begin
        v_d[i] = in_v[i] | inj_ok_c[i];
        c_d[i] = in_v[i] ? in_c[i] : inj_cause[i*CW +: CW];
        t_d[i] = in_v[i] ? in_t[i] : inj_val[i*XLEN +: XLEN];
      end else if (!v_q[i] && inj_ok_c[i]) begin
        v_d[i] = 1'b1;
        c_d[i] = inj_cause[i*CW +: CW];
        t_d[i] = inj_val[i*XLEN +: XLEN];
      end
    end
  end

  // Highest-numbered pending line wins
  always_comb begin
    irq_idx_c = '0;
    for (int k = 0; k < IRQ_W; k++) begin
      if (irq_pending[k]) irq_idx_c = IW'(k);
    end
  end

  // Trap FSM and registered trap outputs
  always_comb begin
    state_d      = state_q;
    trap_valid_d = trap_valid_q;
    trap_irq_d   = trap_irq_q;
    trap_cause_d = trap_cause_q;
    trap_val_d   = trap_val_q;
    unique case (state_q)
      S_IDLE: begin
        if (commit_valid && (v_q[LAST] || irq_take_c)) begin
          state_d      = S_TRAP;
          trap_valid_d = 1'b1;
          if (v_q[LAST]) begin
            trap_irq_d   = 1'b0;
            trap_cause_d = XLEN'(c_q[LAST]);
            trap_val_d   = t_q[LAST];
          end else begin
            trap_irq_d             = 1'b1;
            trap_cause_d           = XLEN'(irq_idx_c);
            trap_cause_d[XLEN-1]   = 1'b1;
            trap_val_d             = '0;
          end
        end
      end
      S_TRAP: begin
        if (trap_ack) begin
          state_d      = S_DRAIN;
          trap_valid_d = 1'b0;
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      v_q          <= '0;
      for (int i = 0; i < NSTG; i++) begin
        c_q[i] <= '0;
        t_q[i] <= '0;
      end
      trap_valid_q <= 1'b0;
      trap_irq_q   <= 1'b0;
      trap_cause_q <= '0;
      trap_val_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      v_q          <= v_d;
      for (int i = 0; i < NSTG; i++) begin
        c_q[i] <= c_d[i];
        t_q[i] <= t_d[i];
      end
      trap_valid_q <= trap_valid_d;
      trap_irq_q   <= trap_irq_d;
      trap_cause_q <= trap_cause_d;
      trap_val_q   <= trap_val_d;
      busy_q       <= busy_d;
    end
  end

  assign trap_valid = trap_valid_q;
  assign trap_irq   = trap_irq_q;
  assign trap_cause = trap_cause_q;
  assign trap_val   = trap_val_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_exc_pipe.sv
// Scoreboard bench for exc_pipe: expected traps are queued when stimulus is driven
// and compared when the DUT raises trap_valid.
module tb_exc_pipe;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NSTG  = 5;
  localparam int unsigned CW    = 6;
  localparam int unsigned IRQ_W = 16;

  typedef struct packed {
    logic            irq;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] val;
  } trap_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NSTG-1:0]      inj_valid;
  logic [NSTG*CW-1:0]   inj_cause;
  logic [NSTG*XLEN-1:0] inj_val;
  logic [NSTG-1:0]      stall;
  logic [NSTG-1:0]      flush;
  logic                 commit_valid;
  logic [IRQ_W-1:0]     irq_pending;
  logic                 irq_enable;
  logic                 trap_valid;
  logic                 trap_irq;
  logic [XLEN-1:0]      trap_cause;
  logic [XLEN-1:0]      trap_val;
  logic                 trap_ack;
  logic                 busy;

  trap_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  exc_pipe #(.XLEN(XLEN), .NSTG(NSTG), .CW(CW), .IRQ_W(IRQ_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .inj_valid(inj_valid), .inj_cause(inj_cause), .inj_val(inj_val),
    .stall(stall), .flush(flush), .commit_valid(commit_valid),
    .irq_pending(irq_pending), .irq_enable(irq_enable),
    .trap_valid(trap_valid), .trap_irq(trap_irq), .trap_cause(trap_cause),
    .trap_val(trap_val), .trap_ack(trap_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inj(input int s, input logic [CW-1:0] c, input logic [XLEN-1:0] v);
    inj_valid[s]           = 1'b1;
    inj_cause[s*CW +: CW]  = c;
    inj_val[s*XLEN +: XLEN] = v;
  endtask

  task automatic clr_inj();
    inj_valid = '0;
    inj_cause = '0;
    inj_val   = '0;
  endtask

  task automatic push_exp(input logic irq, input logic [XLEN-1:0] c, input logic [XLEN-1:0] v);
    trap_t e;
    e.irq = irq; e.cause = c; e.val = v;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for trap_valid, then pop the scoreboard and compare
  task automatic wait_trap(input string tag, output trap_t e, output int lat);
    lat = 0;
    e   = '0;
    while (!trap_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_seen"}, 64'(trap_valid), 64'd1);
    chk({tag, "_sb"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk({tag, "_irq"},   64'(trap_irq), 64'(e.irq));
    chk({tag, "_cause"}, trap_cause, e.cause);
    chk({tag, "_val"},   trap_val, e.val);
    chk({tag, "_busy"},  64'(busy), 64'd1);
  endtask

  // Hold the ack off for 'hold' cycles (toggling irq lines), then ack and check the drain
  task automatic ack_trap(input string tag, input trap_t e, input int hold);
    for (int n = 0; n < hold; n++) begin
      irq_pending = IRQ_W'($urandom) | 16'h8000;
      step();
      chk({tag, "_hold_v"},     64'(trap_valid), 64'd1);
      chk({tag, "_hold_cause"}, trap_cause, e.cause);
      chk({tag, "_hold_val"},   trap_val, e.val);
      chk({tag, "_hold_irq"},   64'(trap_irq), 64'(e.irq));
      chk({tag, "_hold_busy"},  64'(busy), 64'd1);
    end
    irq_enable  = 1'b0;
    irq_pending = '0;
    trap_ack    = 1'b1;
    step();
    trap_ack = 1'b0;
    chk({tag, "_drain_v"},    64'(trap_valid), 64'd0);
    chk({tag, "_drain_busy"}, 64'(busy), 64'd1);
    step();
    chk({tag, "_idle_busy"},  64'(busy), 64'd0);
  endtask

  // No trap may appear for n cycles
  task automatic quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      step();
      if (trap_valid) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    trap_t e;
    int    lat;
    rst_n = 1'b0;
    clr_inj();
    stall = '0; flush = '0; commit_valid = 1'b1;
    irq_pending = '0; irq_enable = 1'b0; trap_ack = 1'b0;
    #12;
    chk("rst_valid", 64'(trap_valid), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_cause", trap_cause, 64'd0);
    chk("rst_val",   trap_val, 64'd0);
    chk("rst_irq",   64'(trap_irq), 64'd0);
    #10 rst_n = 1'b1;
    step();

    // Exception injected at stage 1 travels to commit
    set_inj(1, 6'd2, 64'hDEAD);
    push_exp(1'b0, 64'd2, 64'hDEAD);
    step();
    clr_inj();
    wait_trap("pass", e, lat);
    chk("pass_lat", 64'(lat), 64'd4);
    ack_trap("pass", e, 0);
    quiet("pass_quiet", 6);

    // Older exception beats a later injection on the same instruction
    set_inj(0, 6'd1, 64'h1000);
    push_exp(1'b0, 64'd1, 64'h1000);
    step();
    clr_inj();
    step(); step();
    set_inj(3, 6'd2, 64'h2222);
    step();
    clr_inj();
    wait_trap("older", e, lat);
    ack_trap("older", e, 0);

    // Capture while stalled, record retained
    stall = 5'b11100;
    set_inj(2, 6'd5, 64'h55);
    push_exp(1'b0, 64'd5, 64'h55);
    step();
    clr_inj();
    step(); step();
    stall = '0;
    wait_trap("stall", e, lat);
    ack_trap("stall", e, 0);
    quiet("stall_quiet", 8);

    // Same, but flushed the cycle after injection: no trap
    stall = 5'b11100;
    set_inj(2, 6'd5, 64'h55);
    step();
    clr_inj();
    flush[2] = 1'b1;
    step();
    flush = '0;
    stall = '0;
    quiet("flush_notrap", 10);

    // Interrupt arbitration: highest line of 0x0880 is 11
    irq_enable  = 1'b1;
    irq_pending = 16'h0880;
    push_exp(1'b1, 64'h8000_0000_0000_000B, 64'd0);
    wait_trap("irq", e, lat);
    ack_trap("irq", e, 0);

    // Synchronous exception beats a pending interrupt; record waits while commit_valid=0
    commit_valid = 1'b0;
    irq_enable   = 1'b1;
    irq_pending  = 16'h0880;
    set_inj(4, 6'd3, 64'h33);
    step();
    clr_inj();
    chk("nocommit_v", 64'(trap_valid), 64'd0);
    commit_valid = 1'b1;
    push_exp(1'b0, 64'd3, 64'h33);
    wait_trap("exc_vs_irq", e, lat);
    ack_trap("exc_vs_irq", e, 0);

    // Flush of commit stage in the trap cycle: trap still taken
    commit_valid = 1'b0;
    set_inj(4, 6'd7, 64'h77);
    step();
    clr_inj();
    commit_valid = 1'b1;
    flush[4]     = 1'b1;
    push_exp(1'b0, 64'd7, 64'h77);
    wait_trap("flush_commit", e, lat);
    flush = '0;
    ack_trap("flush_commit", e, 0);

    // Handshake hold with irq lines toggling
    irq_enable  = 1'b1;
    irq_pending = 16'h0001;
    push_exp(1'b1, 64'h8000_0000_0000_0000, 64'd0);
    wait_trap("hold", e, lat);
    ack_trap("hold", e, 4);
    quiet("hold_quiet", 4);

    // Asynchronous reset while in TRAP
    irq_enable  = 1'b1;
    irq_pending = 16'h0020;
    push_exp(1'b1, 64'h8000_0000_0000_0005, 64'd0);
    wait_trap("arst", e, lat);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(trap_valid), 64'd0);
    chk("arst_busy",  64'(busy), 64'd0);
    chk("arst_cause", trap_cause, 64'd0);
    chk("arst_val",   trap_val, 64'd0);
    chk("arst_irq",   64'(trap_irq), 64'd0);
    irq_enable  = 1'b0;
    irq_pending = '0;
    #3 rst_n = 1'b1;
    step();
    chk("arst_idle_busy",  64'(busy), 64'd0);
    chk("arst_idle_valid", 64'(trap_valid), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
